// File: rtl/cpu_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_cycle_ctrl
// Instruction-cycle controller for the 8-bit RISC core.
//
// After reset the controller waits in IDLE for the fetch phase to start.
// Depending on START_EDGE, this is a fetch rising edge or fetch held high.
// It then free-runs an 8-clock instruction cycle (S0..S7) and decodes the
// IR opcode and the ALU zero flag into the datapath control strobes.
// HLT parks the controller in HALT until reset.
//
// Parameters
//   OPW        opcode width (HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7)
//   START_EDGE 1: leave IDLE on a fetch 0->1 edge; 0: on fetch level high
//
// Ports
//   clk          in   controller clock (clk1 from the clock generator)
//   reset        in   synchronous, active-high
//   fetch        in   fetch phase from the clock generator
//   opcode       in   IR[7:5], stable from S2 through S7
//   zero         in   accumulator-is-zero flag from the ALU
//   load_ir      out  IR byte load strobe
//   rd           out  memory read enable
//   wr           out  memory write enable
//   inc_pc       out  PC increment strobe
//   load_pc      out  PC parallel-load strobe
//   load_acc     out  accumulator load strobe
//   datactl_ena  out  drive ACC onto the data bus
//   halt         out  core halted
//   busy         out  high while executing S0..S7
// ---------------------------------------------------------------------------
module cpu_cycle_ctrl #(
    parameter int OPW        = 3,
    parameter bit START_EDGE = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           fetch,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           load_ir,
    output logic           rd,
    output logic           wr,
    output logic           inc_pc,
    output logic           load_pc,
    output logic           load_acc,
    output logic           datactl_ena,
    output logic           halt,
    output logic           busy
);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_S0   = 4'd1,
        ST_S1   = 4'd2,
        ST_S2   = 4'd3,
        ST_S3   = 4'd4,
        ST_S4   = 4'd5,
        ST_S5   = 4'd6,
        ST_S6   = 4'd7,
        ST_S7   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   fetch_q_reg;

    // One-hot opcode decode. The full opcode width is compared, so values
    // above 7 (OPW > 3) match nothing and behave as NOP in S4..S7.
    logic [7:0] op_hit;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_op_decode
            assign op_hit[gi] = (opcode == OPW'(gi));
        end
    endgenerate

    logic op_hlt, op_skz, op_sto, op_jmp, op_alu;
    assign op_hlt = op_hit[0];
    assign op_skz = op_hit[1];
    assign op_sto = op_hit[6];
    assign op_jmp = op_hit[7];
    // ADD, AND, XOR and LDA share the same memory-read / ACC-load pattern.
    assign op_alu = op_hit[2] | op_hit[3] | op_hit[4] | op_hit[5];

    logic start_cond;
    assign start_cond = START_EDGE ? (fetch & ~fetch_q_reg) : fetch;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            fetch_q_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            fetch_q_reg <= fetch;
        end
    end

    // Next-state logic. Once running, fetch is ignored and the cycle is
    // exactly eight clocks long.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start_cond) state_next = ST_S0;
            ST_S0:   state_next = ST_S1;
            ST_S1:   state_next = ST_S2;
            ST_S2:   state_next = ST_S3;
            ST_S3:   state_next = ST_S4;
            ST_S4:   state_next = ST_S5;
            ST_S5:   state_next = ST_S6;
            ST_S6:   state_next = ST_S7;
            ST_S7:   state_next = op_hlt ? ST_HALT : ST_S0;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    // Strobe decode. Reset forces every strobe low combinationally, so a
    // reset asserted mid-instruction cannot let a write or load leak
    // through on the clock edge that takes the state back to IDLE.
    always_comb begin
        load_ir     = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        load_acc    = 1'b0;
        datactl_ena = 1'b0;
        if (!reset) begin
            case (state_reg)
                ST_S0: begin
                    rd      = 1'b1;
                    load_ir = 1'b1;
                end
                ST_S1: begin
                    rd      = 1'b1;
                    load_ir = 1'b1;
                    inc_pc  = 1'b1;
                end
                ST_S3: inc_pc = 1'b1;
                ST_S4: begin
                    load_pc     = op_jmp;
                    rd          = op_alu;
                    datactl_ena = op_sto;
                end
                ST_S5: begin
                    rd          = op_alu;
                    load_acc    = op_alu;
                    datactl_ena = op_sto;
                    wr          = op_sto;
                    inc_pc      = op_jmp;
                    load_pc     = op_jmp;
                end
                ST_S6: begin
                    datactl_ena = op_sto;
                    rd          = op_alu;
                end
                // zero only matters here: SKZ skips the next instruction.
                ST_S7: inc_pc = op_skz & zero;
                default: ;
            endcase
        end
    end

    assign halt = (state_reg == ST_HALT);
    assign busy = (state_reg != ST_IDLE) && (state_reg != ST_HALT);

    // Bus and load-path exclusivity.
    a_rd_wr_excl: assert property (@(posedge clk) !(rd && wr));
    a_pc_acc_excl: assert property (@(posedge clk) !(load_pc && load_acc));

endmodule
